// File: rtl/veggie_split_ctrl.sv
// Motion and slash controller for one veggie: launches it, integrates ballistic
// motion once per frame, splits it on a slash hit, and flags when it has left the screen.
module veggie_split_ctrl #(
  parameter int WIDTH    = 256,
  parameter int HEIGHT   = 256,
  parameter int SCREEN_W = 1024,
  parameter int SCREEN_H = 768,
  parameter int GRAVITY  = 1,
  parameter int SEP_VX   = 2
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic        new_frame_in,
  input  logic        launch_in,
  input  logic [10:0] launch_x_in,
  input  logic [4:0]  launch_vx_in,
  input  logic [7:0]  launch_vy_in,
  input  logic        slash_valid_in,
  input  logic [10:0] slash_x_in,
  input  logic [9:0]  slash_y_in,
  input  logic [9:0]  slash_angle_in,
  output logic [10:0] top_x_out,
  output logic [9:0]  top_y_out,
  output logic [10:0] bot_x_out,
  output logic [9:0]  bot_y_out,
  output logic        split_out,
  output logic [9:0]  angle_out,
  output logic        veggie_gone_out,
  output logic        score_pulse_out,
  output logic        busy_out
);

  localparam logic signed [12:0] LAUNCH_Y = 13'(SCREEN_H + HEIGHT / 2);
  localparam logic signed [12:0] X_LO     = 13'(-(WIDTH / 2));
  localparam logic signed [12:0] X_HI     = 13'(SCREEN_W + WIDTH / 2);
  localparam logic signed [13:0] HALF_W   = 14'(WIDTH / 2);
  localparam logic signed [13:0] HALF_H   = 14'(HEIGHT / 2);
  localparam logic signed [8:0]  GRAV     = 9'(GRAVITY);
  localparam logic signed [5:0]  SEP      = 6'(SEP_VX);

  typedef enum logic [1:0] {IDLE, FLYING, SPLIT, GONE} state_t;

  state_t state, next_state;

  logic signed [12:0] tx, ty, bx, by, tx_d, ty_d, bx_d, by_d;
  logic signed [5:0]  tvx, bvx, tvx_d, bvx_d;
  logic signed [7:0]  vy, vy_d;

  logic signed [12:0] tx_upd, ty_upd, bx_upd, by_upd;
  logic signed [8:0]  vy_sum;
  logic signed [7:0]  vy_upd;
  logic signed [13:0] dx, dy, adx, ady;
  logic               hit, exit_top, exit_bot, do_split;

  logic [10:0] top_x_d, bot_x_d;
  logic [9:0]  top_y_d, bot_y_d, angle_d;
  logic        split_d, gone_d, score_d, busy_d;

  function automatic logic [10:0] clamp_x(input logic signed [12:0] p);
    if (p < 13'sd0)         return 11'd0;
    else if (p > 13'sd2047) return 11'h7FF;
    else                    return p[10:0];
  endfunction

  function automatic logic [9:0] clamp_y(input logic signed [12:0] p);
    if (p < 13'sd0)         return 10'd0;
    else if (p > 13'sd1023) return 10'h3FF;
    else                    return p[9:0];
  endfunction

  function automatic logic off_screen(input logic signed [12:0] x, input logic signed [12:0] y,
                                      input logic signed [7:0] v);
    return ((y > LAUNCH_Y) && (v > 8'sd0)) || (x < X_LO) || (x > X_HI);
  endfunction

  // Candidate physics step, hit test on pre-update positions, and exit tests on updated positions
  always_comb begin
    tx_upd   = tx + 13'(tvx);
    bx_upd   = bx + 13'(bvx);
    ty_upd   = ty + 13'(vy);
    by_upd   = by + 13'(vy);
    vy_sum   = 9'(vy) + GRAV;
    vy_upd   = (vy_sum > 9'sd127) ? 8'sd127 : vy_sum[7:0];
    dx       = $signed({3'b000, slash_x_in}) - 14'(tx);
    dy       = $signed({4'b0000, slash_y_in}) - 14'(ty);
    adx      = dx[13] ? -dx : dx;
    ady      = dy[13] ? -dy : dy;
    hit      = slash_valid_in && (adx < HALF_W) && (ady < HALF_H);
    exit_top = off_screen(tx_upd, ty_upd, vy_upd);
    exit_bot = off_screen(bx_upd, by_upd, vy_upd);
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (launch_in) next_state = FLYING;
      FLYING: begin
        if (new_frame_in && exit_top) next_state = GONE;
        else if (hit)                 next_state = SPLIT;
      end
      SPLIT:   if (new_frame_in && exit_top && exit_bot) next_state = GONE;
      GONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next values of the kinematic state and of every registered output
  always_comb begin
    tx_d     = tx;
    ty_d     = ty;
    bx_d     = bx;
    by_d     = by;
    tvx_d    = tvx;
    bvx_d    = bvx;
    vy_d     = vy;
    split_d  = split_out;
    angle_d  = angle_out;
    score_d  = 1'b0;
    gone_d   = 1'b0;
    do_split = (state == FLYING) && (next_state == SPLIT);

    if ((state == IDLE) && launch_in) begin
      tx_d  = {2'b00, launch_x_in};
      bx_d  = {2'b00, launch_x_in};
      ty_d  = LAUNCH_Y;
      by_d  = LAUNCH_Y;
      tvx_d = {launch_vx_in[4], launch_vx_in};
      bvx_d = {launch_vx_in[4], launch_vx_in};
      vy_d  = launch_vy_in;
    end

    if (((state == FLYING) || (state == SPLIT)) && new_frame_in) begin
      tx_d = tx_upd;
      bx_d = bx_upd;
      ty_d = ty_upd;
      by_d = by_upd;
      vy_d = vy_upd;
    end

    // Separation applies to velocity only, so a coincident frame moves with the old vx
    if (do_split) begin
      tvx_d   = tvx - SEP;
      bvx_d   = bvx + SEP;
      split_d = 1'b1;
      angle_d = slash_angle_in;
      score_d = 1'b1;
    end

    if (next_state == GONE) begin
      gone_d  = 1'b1;
      split_d = 1'b0;
      angle_d = 10'd0;
    end

    busy_d  = (next_state == FLYING) || (next_state == SPLIT);
    top_x_d = clamp_x(tx_d);
    top_y_d = clamp_y(ty_d);
    bot_x_d = clamp_x(bx_d);
    bot_y_d = clamp_y(by_d);
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      tx              <= '0;
      ty              <= '0;
      bx              <= '0;
      by              <= '0;
      tvx             <= '0;
      bvx             <= '0;
      vy              <= '0;
      top_x_out       <= '0;
      top_y_out       <= '0;
      bot_x_out       <= '0;
      bot_y_out       <= '0;
      split_out       <= 1'b0;
      angle_out       <= '0;
      veggie_gone_out <= 1'b0;
      score_pulse_out <= 1'b0;
      busy_out        <= 1'b0;
    end else begin
      tx              <= tx_d;
      ty              <= ty_d;
      bx              <= bx_d;
      by              <= by_d;
      tvx             <= tvx_d;
      bvx             <= bvx_d;
      vy              <= vy_d;
      top_x_out       <= top_x_d;
      top_y_out       <= top_y_d;
      bot_x_out       <= bot_x_d;
      bot_y_out       <= bot_y_d;
      split_out       <= split_d;
      angle_out       <= angle_d;
      veggie_gone_out <= gone_d;
      score_pulse_out <= score_d;
      busy_out        <= busy_d;
    end
  end

endmodule

// File: doc/veggie_split_ctrl.md
Name: veggie_split_ctrl

Overview:
- Per-veggie motion and slash controller; drives the position and split inputs of the two split sprite renderers (top half, bottom half) for one veggie.
- Launches a veggie from below the screen and integrates ballistic motion once per frame.
- Tests slash events against the sprite box. On a hit it splits the veggie into two halves that separate horizontally, then reports when both halves have left the screen.

Parameters:
- WIDTH, 256, sprite width in pixels.
- HEIGHT, 256, sprite height in pixels.
- SCREEN_W, 1024, visible width.
- SCREEN_H, 768, visible height.
- GRAVITY, 1, added to vy each frame.
- SEP_VX, 2, horizontal separation speed added to each half at split.

Ports:
- pixel_clk_in  in  1  pixel clock
- rst_in  in  1  synchronous active-high reset
- new_frame_in  in  1  one-cycle pulse per frame (start of vblank)
- launch_in  in  1  request launch
- launch_x_in  in  11  launch centre x
- launch_vx_in  in  5  signed initial vx
- launch_vy_in  in  8  signed initial vy (negative = up)
- slash_valid_in  in  1  one-cycle slash event
- slash_x_in  in  11  slash point x
- slash_y_in  in  10  slash point y
- slash_angle_in  in  10  cut angle
- top_x_out  out  11  top-half centre x
- top_y_out  out  10  top-half centre y
- bot_x_out  out  11  bottom-half centre x
- bot_y_out  out  10  bottom-half centre y
- split_out  out  1  high once veggie is cut
- angle_out  out  10  latched cut angle
- veggie_gone_out  out  1  high for one cycle when veggie exits
- score_pulse_out  out  1  one-cycle pulse on a hit
- busy_out  out  1  high in FLYING or SPLIT

Behaviour:
- Reset (synchronous, active-high): state IDLE. All outputs 0. Internal positions and velocities 0. A reset mid-flight aborts the veggie with no gone pulse.
- Internal state:
  - Positions are signed 13-bit: tx, ty, bx, by.
  - Velocities: tvx and bvx are signed 6-bit; vy is signed 8-bit, shared by both halves.
  - vy saturates at +127.
- Output positions: each internal position is clamped to [0, 2047] for x and [0, 1023] for y.
- IDLE:
  - On launch_in: tx = bx = launch_x_in; ty = by = SCREEN_H + HEIGHT/2 (896); tvx = bvx = launch_vx_in; vy = launch_vy_in; go to FLYING.
  - launch_in has priority over a simultaneous new_frame_in; no physics update is applied that cycle.
  - launch_in is ignored in every other state.
- Physics, applied in FLYING and SPLIT on each new_frame_in:
  - x += vx for each half.
  - y += vy.
  - Then vy += GRAVITY.
  - Results are registered and visible on the cycle after new_frame_in.
- FLYING:
  - Hit test on slash_valid_in: |slash_x_in − tx| < WIDTH/2 and |slash_y_in − ty| < HEIGHT/2, using pre-update positions.
  - On a hit: angle_out <= slash_angle_in; split_out <= 1; score_pulse_out high one cycle; tvx -= SEP_VX; bvx += SEP_VX; go to SPLIT.
  - If the hit and new_frame_in arrive in the same cycle, the physics update uses the old (pre-split) vx.
  - A slash that misses has no effect.
- SPLIT:
  - Slash events are ignored.
  - split_out and angle_out stay held.
- Exit condition, checked after each update:
  - ty > SCREEN_H + HEIGHT/2 with vy > 0, OR tx < −WIDTH/2, OR tx > SCREEN_W + WIDTH/2.
  - In SPLIT the condition must hold for both halves.
  - When it holds: go to GONE.
- GONE: veggie_gone_out high for exactly one cycle; clear split_out and angle_out; go to IDLE next cycle.
- busy_out = (state == FLYING or SPLIT).

Test Plan:
- Reset with launch_in held high → all outputs 0 throughout reset; launch_in is acted on in the first non-reset cycle.
- Launch x=512, vx=0, vy=−30; apply 30 frames → top_y_out = 431; vy = 0; busy_out = 1; split_out = 0.
- Continue with no slash → veggie_gone_out pulses one cycle after frame 62 (y = 927); then busy_out = 0 and the block is IDLE.
- At y=431, slash (520, 440, angle 90) → score_pulse_out one cycle; split_out = 1; angle_out = 90. After 5 more frames top_x_out = 502 and bot_x_out = 522.
- Slash at (700, 431) with centre (512, 431) → no effect. A second slash while in SPLIT → no score pulse.
- Slash hit coincident with new_frame_in → positions update with the old vx; split takes effect, and separation starts on the next frame.
